// File: rtl/divf_if.sv
// Valid/ready operand and result channels of the sequential float divider.
interface divf_if #(parameter int W = 32);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] s;
  logic         dz;

  modport master (output in_valid, a, b, out_ready, input in_ready, out_valid, s, dz);
  modport slave  (input in_valid, a, b, out_ready, output in_ready, out_valid, s, dz);
endinterface

// File: rtl/divf_seq.sv
// Multi-cycle single-precision divider: bit-serial restoring mantissa division,
// truncating normalization, result held until the consumer takes it.
module divf_seq #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int BIAS  = 127
) (
  input  logic   clk,
  input  logic   rst_n,
  divf_if.slave  bus
);
  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int QW = MAN_W + 2;          // quotient bits, one integer bit
  localparam int RW = MAN_W + 3;          // remainder, room for the left shift
  localparam int CW = $clog2(QW);
  localparam logic [EXP_W-1:0] BIAS_E = EXP_W'(BIAS);
  localparam logic [CW-1:0]    K_LAST = CW'(QW - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] DIV  = 2'd1;
  localparam logic [1:0] NORM = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]       state;
  logic             sign;
  logic [EXP_W-1:0] sexp;
  logic [MAN_W:0]   bm;
  logic [RW-1:0]    rem;
  logic [QW-1:0]    q;
  logic [CW-1:0]    k;
  logic [W-1:0]     s_r;
  logic             dz_r;

  logic [EXP_W-1:0] a_exp, b_exp, sexp_n, exp_n;
  logic [RW-1:0]    bx, rem_n;
  logic [MAN_W-1:0] mant_n;
  logic             sign_n, ge, accept;

  assign accept = (state == IDLE) && bus.in_valid;
  assign sign_n = bus.a[W-1] ^ bus.b[W-1];
  assign a_exp  = bus.a[W-2:MAN_W];
  assign b_exp  = bus.b[W-2:MAN_W];
  assign sexp_n = a_exp - b_exp + BIAS_E;

  assign bx     = {2'b00, bm};
  assign ge     = (rem >= bx);
  assign rem_n  = ge ? (rem - bx) : rem;

  // Quotient lies in [0.5, 2): a clear integer bit costs one exponent step.
  assign mant_n = q[QW-1] ? q[QW-2:1] : q[QW-3:0];
  assign exp_n  = q[QW-1] ? sexp : (sexp - EXP_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sign  <= 1'b0;
      sexp  <= '0;
      bm    <= '0;
      rem   <= '0;
      q     <= '0;
      k     <= '0;
      s_r   <= '0;
      dz_r  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          sign <= sign_n;
          sexp <= sexp_n;
          bm   <= {1'b1, bus.b[MAN_W-1:0]};
          rem  <= {2'b00, 1'b1, bus.a[MAN_W-1:0]};
          q    <= '0;
          k    <= '0;
          if (bus.b[W-2:0] == '0) begin
            s_r   <= {sign_n, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            dz_r  <= 1'b1;
            state <= DONE;
          end else if (bus.a[W-2:0] == '0) begin
            s_r   <= {sign_n, {(W-1){1'b0}}};
            dz_r  <= 1'b0;
            state <= DONE;
          end else begin
            state <= DIV;
          end
        end
        DIV: begin
          q   <= {q[QW-2:0], ge};
          rem <= {rem_n[RW-2:0], 1'b0};
          k   <= k + CW'(1);
          if (k == K_LAST) state <= NORM;
        end
        NORM: begin
          s_r   <= {sign, exp_n, mant_n};
          dz_r  <= 1'b0;
          state <= DONE;
        end
        default: if (bus.out_ready) state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.s         = s_r;
  assign bus.dz        = dz_r;
endmodule

// File: tb/tb_divf_seq.sv
// Directed vectors for divf_seq; expectations queued at accept, checked at the result handshake.
module tb_divf_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  divf_if bus ();
  divf_seq dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] s;
    logic        dz;
    int          lat;
    int          acc;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %h want %h", name, act, expv);
    end
  endtask

  // Latency counts edges from the accept edge (inclusive) to the edge that raises out_valid.
  task automatic op(input logic [31:0] av, input logic [31:0] bv, input logic [31:0] es,
                    input logic edz, input int elat, input bit hold, input bit track,
                    output int acc);
    exp_t e;
    bit   got = 1'b0;
    acc = -1;
    bus.in_valid = 1'b1;
    bus.a = av;
    bus.b = bv;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (bus.in_ready) got = 1'b1;
    end
    if (!got) begin
      tests++; fails++;
      $display("FAIL accept_timeout: got no in_ready want in_ready");
      bus.in_valid = 1'b0;
      return;
    end
    acc = cyc + 1;
    if (track) begin
      e.s = es; e.dz = edz; e.lat = elat; e.acc = acc;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    if (!hold) begin
      bus.in_valid = 1'b0;
      bus.a = 32'hDEADBEEF;
      bus.b = 32'h12345678;
    end
  endtask

  task automatic drain();
    bit done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (sb.size() == 0) done = 1'b1;
    end
    if (!done) begin
      tests++; fails++;
      $display("FAIL drain_timeout: got %0d pending want 0", sb.size());
      sb.delete();
    end
    @(posedge clk); #1;
  endtask

  // Monitor: latency, busy-ready and result checks, independent of the stimulus.
  initial begin
    exp_t e;
    bit   prev_ov = 1'b0;
    bit   bad_rdy = 1'b0;
    int   rise = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_ov = 1'b0;
        bad_rdy = 1'b0;
        continue;
      end
      if (sb.size() > 0 && cyc >= sb[0].acc && bus.in_ready) bad_rdy = 1'b1;
      if (bus.out_valid && !prev_ov) rise = cyc;
      prev_ov = bus.out_valid;
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_result: got s=%h want no result", bus.s);
        end else begin
          e = sb.pop_front();
          chk("s", bus.s, e.s);
          chk("dz", {31'b0, bus.dz}, {31'b0, e.dz});
          chk("latency", rise - e.acc + 1, e.lat);
          chk("in_ready_while_busy", {31'b0, bad_rdy}, 32'd0);
          bad_rdy = 1'b0;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, a1, a2;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    bus.a = '0;
    bus.b = '0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
    chk("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("rst_s", bus.s, 32'h0);
    chk("rst_dz", {31'b0, bus.dz}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // 6.0 / 2.0
    op(32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 27, 1'b0, 1'b1, a0);
    drain();
    // 1/3 takes the normalize-shift path; -1.5/0.5 negative sign
    op(32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 1'b0, 27, 1'b0, 1'b1, a0);
    drain();
    op(32'hBFC00000, 32'h3F000000, 32'hC0400000, 1'b0, 27, 1'b0, 1'b1, a0);
    drain();
    // special cases
    op(32'h3F800000, 32'h00000000, 32'h7F800000, 1'b1, 1, 1'b0, 1'b1, a0);
    drain();
    op(32'h80000000, 32'h3F800000, 32'h80000000, 1'b0, 1, 1'b0, 1'b1, a0);
    drain();

    // backpressure: 7.0 / 2.0 = 3.5
    bus.out_ready = 1'b0;
    op(32'h40E00000, 32'h40000000, 32'h40600000, 1'b0, 27, 1'b0, 1'b1, a0);
    for (int i = 0; i < 100 && !bus.out_valid; i++) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      bus.in_valid = (i % 2 == 0);
      bus.a = 32'h3F800000;
      bus.b = 32'h00000000;
      @(negedge clk);
      chk("bp_out_valid", {31'b0, bus.out_valid}, 32'd1);
      chk("bp_in_ready", {31'b0, bus.in_ready}, 32'd0);
      chk("bp_s", bus.s, 32'h40600000);
      chk("bp_dz", {31'b0, bus.dz}, 32'd0);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_release_out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("bp_release_in_ready", {31'b0, bus.in_ready}, 32'd1);
    chk("bp_release_s_held", bus.s, 32'h40600000);
    drain();

    // asynchronous reset in the middle of DIV aborts the operation
    op(32'h40C00000, 32'h40000000, 32'h0, 1'b0, 0, 1'b0, 1'b0, a0);
    repeat (12) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("abort_in_ready", {31'b0, bus.in_ready}, 32'd1);
    chk("abort_s", bus.s, 32'h0);
    chk("abort_dz", {31'b0, bus.dz}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    op(32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 27, 1'b0, 1'b1, a0);
    drain();

    // back-to-back with in_valid held high
    op(32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 27, 1'b1, 1'b1, a0);
    op(32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 1'b0, 27, 1'b1, 1'b1, a1);
    op(32'hBFC00000, 32'h3F000000, 32'hC0400000, 1'b0, 27, 1'b0, 1'b1, a2);
    chk("b2b_spacing_1", a1 - a0, 28);
    chk("b2b_spacing_2", a2 - a1, 28);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
